inst_fetch: RTL and testbench

Instruction fetch stage that sits directly downstream of the PC register. It takes the current PC, issues a single-outstanding request to instruction memory over a req/ack handshake, and queues returned {pc, instruction} pairs in a small FIFO for the decode stage. It drives the PC register's pause input so the PC advances only when an instruction has been accepted or a redirect occurs. It also handles branch/exception flushes, including discarding a response that is still in flight.

---
 rtl/inst_fetch.sv | 126 ++++++++++++
 tb/tb_inst_fetch.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch
// Brief    : Single-outstanding instruction fetch with a {pc, inst} FIFO.
// Revision : 1.0  initial release
// ============================================================================
module inst_fetch #(
   parameter int unsigned DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_in,
   output logic        pc_pause,
   input  logic        flush,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_pc,
   output logic [31:0] id_inst
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] c_full    = (AW + 1)'(DEPTH);
   localparam logic [AW:0] c_cnt_one = (AW + 1)'(1);
   localparam logic [AW-1:0] c_ptr_one = AW'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [31:0]   r_req_pc;
   logic          w_issue;
   logic          w_push;
   logic          w_pop;
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_count;
   logic [31:0]   r_pc_mem   [DEPTH];
   logic [31:0]   r_inst_mem [DEPTH];

   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      w_push      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!flush && (r_count < c_full)) begin
               w_issue     = 1'b1;
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            // An ack coincident with a flush belongs to the old path: drop it.
            if (imem_ack) begin
               w_push      = ~flush;
               w_state_nxt = S_IDLE;
            end else if (flush) begin
               w_state_nxt = S_DROP;
            end
         end
         S_DROP: begin
            if (imem_ack) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign id_valid  = (r_count != '0);
   assign w_pop     = id_valid & id_ready;
   assign pc_pause  = ~(w_push | flush);
   assign imem_req  = (r_state != S_IDLE);
   assign imem_addr = r_req_pc;
   assign id_pc     = id_valid ? r_pc_mem[r_rptr]   : 32'd0;
   assign id_inst   = id_valid ? r_inst_mem[r_rptr] : 32'd0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_req_pc <= 32'd0;
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_count  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_issue) begin
            r_req_pc <= pc_in;
         end
         if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
         end else begin
            if (w_push) begin
               r_wptr <= r_wptr + c_ptr_one;
            end
            if (w_pop) begin
               r_rptr <= r_rptr + c_ptr_one;
            end
            if (w_push && !w_pop) begin
               r_count <= r_count + c_cnt_one;
            end else if (w_pop && !w_push) begin
               r_count <= r_count - c_cnt_one;
            end
         end
      end
   end

   // Storage needs no reset; reads are masked by id_valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_pc_mem[r_wptr]   <= r_req_pc;
         r_inst_mem[r_wptr] <= imem_rdata;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch
// Brief    : Directed vector table plus randomized run against a request-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_inst_fetch;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] pc_in = 32'd0;
   logic        pc_pause;
   logic        flush = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic        id_valid;
   logic        id_ready = 1'b0;
   logic [31:0] id_pc;
   logic [31:0] id_inst;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   inst_fetch #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .pc_in      (pc_in),
      .pc_pause   (pc_pause),
      .flush      (flush),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .id_valid   (id_valid),
      .id_ready   (id_ready),
      .id_pc      (id_pc),
      .id_inst    (id_inst)
   );

   typedef struct {
      logic [31:0] pc;
      logic        fl;
      logic        ack;
      logic [31:0] rd;
      logic        rdy;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_pause;
      logic        e_vld;
      logic [31:0] e_pc;
      logic [31:0] e_inst;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   vec_t tbl [17];
   ent_t q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] pc, input logic fl, input logic ack,
                               input logic [31:0] rd, input logic rdy, input logic er,
                               input logic [31:0] ea, input logic ep, input logic ev,
                               input logic [31:0] epc, input logic [31:0] einst);
      vec_t v;
      v.pc = pc; v.fl = fl; v.ack = ack; v.rd = rd; v.rdy = rdy;
      v.e_req = er; v.e_addr = ea; v.e_pause = ep; v.e_vld = ev;
      v.e_pc = epc; v.e_inst = einst;
      return v;
   endfunction

   function automatic logic [31:0] memw(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " req"},   imem_req,  1'b0);
      chk({tag, " addr"},  imem_addr, 32'd0);
      chk({tag, " pause"}, pc_pause,  1'b1);
      chk({tag, " vld"},   id_valid,  1'b0);
      chk({tag, " idpc"},  id_pc,     32'd0);
      chk({tag, " inst"},  id_inst,   32'd0);
   endtask

   initial begin
      logic        outst, live, exp_valid, exp_req, exp_pause;
      logic [31:0] exp_addr, req_addr, pc_reg, target;
      int          drv_d, drv_cnt;
      logic        drv_busy;

      // columns: pc_in flush ack rdata id_ready | req addr pause valid id_pc id_inst
      tbl[0]  = mk(32'h000, 0, 0, 32'h0,        1, 0, 32'h000, 1, 0, 32'h000, 32'h0);
      tbl[1]  = mk(32'h000, 0, 1, 32'hA0,       1, 1, 32'h000, 0, 0, 32'h000, 32'h0);
      tbl[2]  = mk(32'h004, 0, 0, 32'h0,        0, 0, 32'h000, 1, 1, 32'h000, 32'hA0);
      tbl[3]  = mk(32'h004, 0, 0, 32'h0,        0, 1, 32'h004, 1, 1, 32'h000, 32'hA0);
      tbl[4]  = mk(32'h004, 0, 1, 32'hA4,       0, 1, 32'h004, 0, 1, 32'h000, 32'hA0);
      tbl[5]  = mk(32'h008, 0, 0, 32'h0,        0, 0, 32'h000, 1, 1, 32'h000, 32'hA0);
      tbl[6]  = mk(32'h008, 0, 0, 32'h0,        1, 0, 32'h000, 1, 1, 32'h000, 32'hA0);
      tbl[7]  = mk(32'h008, 0, 0, 32'h0,        0, 0, 32'h000, 1, 1, 32'h004, 32'hA4);
      tbl[8]  = mk(32'h008, 1, 0, 32'h0,        0, 1, 32'h008, 0, 1, 32'h004, 32'hA4);
      tbl[9]  = mk(32'h100, 0, 0, 32'h0,        1, 1, 32'h008, 1, 0, 32'h000, 32'h0);
      tbl[10] = mk(32'h100, 0, 1, 32'hDEADBEEF, 1, 1, 32'h008, 1, 0, 32'h000, 32'h0);
      tbl[11] = mk(32'h100, 0, 0, 32'h0,        1, 0, 32'h000, 1, 0, 32'h000, 32'h0);
      tbl[12] = mk(32'h100, 0, 1, 32'hB0,       0, 1, 32'h100, 0, 0, 32'h000, 32'h0);
      tbl[13] = mk(32'h104, 0, 0, 32'h0,        0, 0, 32'h000, 1, 1, 32'h100, 32'hB0);
      tbl[14] = mk(32'h104, 1, 1, 32'hB4,       0, 1, 32'h104, 0, 1, 32'h100, 32'hB0);
      tbl[15] = mk(32'h200, 0, 0, 32'h0,        0, 0, 32'h000, 1, 0, 32'h000, 32'h0);
      tbl[16] = mk(32'h200, 0, 0, 32'h0,        0, 1, 32'h200, 1, 0, 32'h000, 32'h0);

      repeat (2) @(posedge clk);
      #1 chk_reset_outputs("reset");
      rst = 1'b1;

      for (int i = 0; i < 17; i++) begin
         pc_in = tbl[i].pc; flush = tbl[i].fl; imem_ack = tbl[i].ack;
         imem_rdata = tbl[i].rd; id_ready = tbl[i].rdy;
         #3;
         chk($sformatf("row%0d req", i), imem_req, tbl[i].e_req);
         if (tbl[i].e_req) chk($sformatf("row%0d addr", i), imem_addr, tbl[i].e_addr);
         chk($sformatf("row%0d pause", i), pc_pause, tbl[i].e_pause);
         chk($sformatf("row%0d vld", i),   id_valid, tbl[i].e_vld);
         chk($sformatf("row%0d idpc", i),  id_pc,    tbl[i].e_pc);
         chk($sformatf("row%0d inst", i),  id_inst,  tbl[i].e_inst);
         @(posedge clk); #1;
      end

      // Asynchronous reset while a request is outstanding.
      flush = 1'b0; imem_ack = 1'b0; id_ready = 1'b0;
      #2 rst = 1'b0;
      #1 chk_reset_outputs("async_rst");
      @(posedge clk); #1;
      pc_in = 32'h300;
      rst = 1'b1;
      #3 chk("post_rst idle req", imem_req, 1'b0);
      @(posedge clk); #1;
      chk("post_rst req", imem_req, 1'b1);
      chk("post_rst addr", imem_addr, 32'h300);

      // Randomized run against the request-level scoreboard.
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      q.delete();
      outst = 1'b0; live = 1'b0; exp_valid = 1'b0; exp_req = 1'b0;
      exp_addr = 32'd0; req_addr = 32'd0; pc_reg = 32'h1000;
      drv_busy = 1'b0; drv_d = 0; drv_cnt = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         pc_in = pc_reg;
         if (imem_req) begin
            if (!drv_busy) begin
               drv_busy = 1'b1;
               drv_d    = $urandom_range(0, 3);
               drv_cnt  = 0;
            end
            imem_ack   = (drv_cnt == drv_d);
            imem_rdata = memw(imem_addr);
            drv_cnt++;
            if (imem_ack) drv_busy = 1'b0;
         end else begin
            drv_busy   = 1'b0;
            imem_ack   = ($urandom_range(0, 7) == 0);
            imem_rdata = $urandom;
         end
         flush    = ($urandom_range(0, 19) == 0);
         id_ready = ($urandom_range(0, 3) != 0);
         target   = $urandom & 32'h0000FFFC;
         #3;
         if (exp_valid) begin
            chk("rnd req", imem_req, exp_req);
            if (exp_req) chk("rnd addr", imem_addr, exp_addr);
         end
         chk("rnd vld", id_valid, (q.size() != 0));
         if (q.size() != 0) begin
            chk("rnd idpc", id_pc, q[0].pc);
            chk("rnd inst", id_inst, q[0].inst);
         end
         if (imem_req && !outst) begin
            outst = 1'b1; live = 1'b1; req_addr = imem_addr;
         end
         exp_pause = !(flush || (imem_req && imem_ack && live));
         chk("rnd pause", pc_pause, exp_pause);

         exp_valid = 1'b1;
         if (imem_req) begin
            exp_req  = !imem_ack;
            exp_addr = req_addr;
         end else begin
            exp_req  = !flush && (q.size() < DEPTH);
            exp_addr = pc_in;
         end

         if (id_valid && id_ready && !flush && q.size() != 0) void'(q.pop_front());
         if (imem_req && imem_ack) begin
            if (live && !flush) q.push_back('{req_addr, memw(req_addr)});
            outst = 1'b0; live = 1'b0;
         end else if (imem_req && flush) begin
            live = 1'b0;
         end
         if (flush) q.delete();
         if (!exp_pause) pc_reg = flush ? target : pc_reg + 32'd4;
         @(posedge clk); #1;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
